// File: rtl/sad_best_select_if.sv
// SAD tree / candidate MV bundle into sad_best_select, and its per-partition best results back out.
interface sad_best_select_if #(
  parameter int MV_W = 7
);
  logic                    start;
  logic                    sad_valid;
  logic                    sad_ready;
  logic [2*MV_W-1:0]       cand_mv;
  logic [415:0]            SAD4x8;
  logic [415:0]            SAD8x4;
  logic [223:0]            SAD8x8;
  logic [119:0]            SAD8x16;
  logic [119:0]            SAD16x8;
  logic [63:0]             SAD16x16;
  logic [33:0]             SAD16x32;
  logic [33:0]             SAD32x16;
  logic [17:0]             SAD32x32;
  logic                    busy;
  logic                    done;
  logic [105*18-1:0]       best_sad;
  logic [105*2*MV_W-1:0]   best_mv;

  modport master (
    output start, sad_valid, cand_mv,
    output SAD4x8, SAD8x4, SAD8x8, SAD8x16, SAD16x8, SAD16x16, SAD16x32, SAD32x16, SAD32x32,
    input  sad_ready, busy, done, best_sad, best_mv
  );

  modport slave (
    input  start, sad_valid, cand_mv,
    input  SAD4x8, SAD8x4, SAD8x8, SAD8x16, SAD16x8, SAD16x16, SAD16x32, SAD32x16, SAD32x32,
    output sad_ready, busy, done, best_sad, best_mv
  );
endinterface

// File: rtl/sad_best_select.sv
// Per-partition minimum-cost tracker over one integer-ME search for all 105 partitions of a 32x32 CU.
// Optional MV-cost term in the comparison is enabled by defining SAD_MVCOST_EN.
module sad_best_select #(
  parameter int MV_W      = 7,
  parameter int NUM_CAND  = 4096,
  parameter int LAMBDA_SH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  sad_best_select_if.slave  bus_if
);
  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DONE} state_t;

  localparam int          NP       = 105;
  localparam int          MVB      = 2 * MV_W;
  localparam logic [15:0] LAST_IDX = 16'(NUM_CAND - 1);

  state_t      state_q;
  logic [15:0] cnt_q;
  logic        ready_q, busy_q, done_q;
  logic        accept, init, last_acc;

  assign accept   = bus_if.sad_valid & ready_q;
  assign init     = (state_q == S_IDLE) & bus_if.start;
  assign last_acc = accept & (cnt_q == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus_if.start) begin
            state_q <= S_SEARCH;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_SEARCH: begin
          if (accept) begin
            cnt_q <= cnt_q + 16'd1;
            if (cnt_q == LAST_IDX) begin
              state_q <= S_DONE;
              ready_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus_if.sad_ready = ready_q;
  assign bus_if.busy      = busy_q;
  assign bus_if.done      = done_q;

  // Flatten every SAD bus into one zero-extended list ordered by partition index.
  logic [17:0] sad_p [NP];

  for (genvar gi = 0; gi < 32; gi++) begin : g_4x8
    assign sad_p[gi]      = 18'(bus_if.SAD4x8[gi*13 +: 13]);
    assign sad_p[32 + gi] = 18'(bus_if.SAD8x4[gi*13 +: 13]);
  end
  for (genvar gi = 0; gi < 16; gi++) begin : g_8x8
    assign sad_p[64 + gi] = 18'(bus_if.SAD8x8[gi*14 +: 14]);
  end
  for (genvar gi = 0; gi < 8; gi++) begin : g_8x16
    assign sad_p[80 + gi] = 18'(bus_if.SAD8x16[gi*15 +: 15]);
    assign sad_p[88 + gi] = 18'(bus_if.SAD16x8[gi*15 +: 15]);
  end
  for (genvar gi = 0; gi < 4; gi++) begin : g_16x16
    assign sad_p[96 + gi] = 18'(bus_if.SAD16x16[gi*16 +: 16]);
  end
  for (genvar gi = 0; gi < 2; gi++) begin : g_16x32
    assign sad_p[100 + gi] = 18'(bus_if.SAD16x32[gi*17 +: 17]);
    assign sad_p[102 + gi] = 18'(bus_if.SAD32x16[gi*17 +: 17]);
  end
  assign sad_p[104] = bus_if.SAD32x32;

`ifdef SAD_MVCOST_EN
  // Magnitude fits MV_W unsigned bits even for the most negative component.
  logic [MV_W-1:0] mv_x, mv_y, abs_x, abs_y;
  logic [19:0]     mv_cost;
  assign mv_x    = bus_if.cand_mv[MV_W-1:0];
  assign mv_y    = bus_if.cand_mv[MVB-1:MV_W];
  assign abs_x   = mv_x[MV_W-1] ? (~mv_x) + MV_W'(1) : mv_x;
  assign abs_y   = mv_y[MV_W-1] ? (~mv_y) + MV_W'(1) : mv_y;
  assign mv_cost = (20'(abs_x) + 20'(abs_y)) << LAMBDA_SH;
`else
  logic unused_lambda;
  assign unused_lambda = (LAMBDA_SH != 0);
`endif

  logic [NP-1:0][17:0]  best_sad_w;
  logic [NP-1:0][MVB-1:0] best_mv_w;

  for (genvar gi = 0; gi < NP; gi++) begin : g_part
    logic [19:0]    cost, run_cost_q;
    logic [17:0]    run_sad_q, best_sad_q;
    logic [MVB-1:0] run_mv_q, best_mv_q;
    logic           better;

`ifdef SAD_MVCOST_EN
    assign cost = 20'(sad_p[gi]) + mv_cost;
`else
    assign cost = 20'(sad_p[gi]);
`endif
    assign better = cost < run_cost_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        run_cost_q <= '1;
        run_sad_q  <= '0;
        run_mv_q   <= '0;
        best_sad_q <= '0;
        best_mv_q  <= '0;
      end else begin
        if (init) begin
          run_cost_q <= '1;
          run_sad_q  <= '0;
          run_mv_q   <= '0;
        end else if (accept && better) begin
          run_cost_q <= cost;
          run_sad_q  <= sad_p[gi];
          run_mv_q   <= bus_if.cand_mv;
        end
        // Publish on the final accept so best_* are valid in the same cycle done is high.
        if (last_acc) begin
          best_sad_q <= better ? sad_p[gi] : run_sad_q;
          best_mv_q  <= better ? bus_if.cand_mv : run_mv_q;
        end
      end
    end

    assign best_sad_w[gi] = best_sad_q;
    assign best_mv_w[gi]  = best_mv_q;
  end

  assign bus_if.best_sad = best_sad_w;
  assign bus_if.best_mv  = best_mv_w;
endmodule

// File: tb/tb_sad_best_select.sv
// Directed + randomized searches of sad_best_select checked against a per-partition minimum model.
module tb_sad_best_select;
  localparam int MV_W = 7;
  localparam int NC   = 4;
  localparam int LSH  = 2;
  localparam int NP   = 105;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sad_best_select_if #(.MV_W(MV_W)) bus_if ();

  sad_best_select #(.MV_W(MV_W), .NUM_CAND(NC), .LAMBDA_SH(LSH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus_if)
  );

  int checks = 0;
  int failures = 0;
  int csad [NC][NP];
  int cmx [NC];
  int cmy [NC];
  int esad [NP];
  int emx [NP];
  int emy [NP];
  int prev_sad0 = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pw(input int p);
    if (p < 64)  return 13;
    if (p < 80)  return 14;
    if (p < 96)  return 15;
    if (p < 100) return 16;
    if (p < 104) return 17;
    return 18;
  endfunction

  function automatic int rnd_sad(input int p);
    return int'($urandom & ((32'd1 << pw(p)) - 32'd1));
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int mvcost(input int c);
`ifdef SAD_MVCOST_EN
    return (iabs(cmx[c]) + iabs(cmy[c])) * (1 << LSH);
`else
    return 0;
`endif
  endfunction

  function automatic logic [31:0] mvpack(input int mx, input int my);
    logic [6:0] x7, y7;
    x7 = 7'(mx);
    y7 = 7'(my);
    return 32'({y7, x7});
  endfunction

  // Reference: strict-less scan in candidate order, so ties keep the earliest candidate.
  task automatic compute_expected();
    for (int p = 0; p < NP; p++) begin
      int bc;
      bc = 20'hFFFFF;
      esad[p] = 0; emx[p] = 0; emy[p] = 0;
      for (int c = 0; c < NC; c++) begin
        if (csad[c][p] + mvcost(c) < bc) begin
          bc = csad[c][p] + mvcost(c);
          esad[p] = csad[c][p];
          emx[p] = cmx[c];
          emy[p] = cmy[c];
        end
      end
    end
  endtask

  task automatic drive_zero();
    bus_if.SAD4x8 = '0; bus_if.SAD8x4 = '0; bus_if.SAD8x8 = '0;
    bus_if.SAD8x16 = '0; bus_if.SAD16x8 = '0; bus_if.SAD16x16 = '0;
    bus_if.SAD16x32 = '0; bus_if.SAD32x16 = '0; bus_if.SAD32x32 = '0;
    bus_if.cand_mv = 14'($urandom);
  endtask

  task automatic drive_cand(input int c);
    for (int k = 0; k < 32; k++) begin
      bus_if.SAD4x8[k*13 +: 13] = 13'(csad[c][k]);
      bus_if.SAD8x4[k*13 +: 13] = 13'(csad[c][32 + k]);
    end
    for (int k = 0; k < 16; k++) bus_if.SAD8x8[k*14 +: 14] = 14'(csad[c][64 + k]);
    for (int k = 0; k < 8; k++) begin
      bus_if.SAD8x16[k*15 +: 15] = 15'(csad[c][80 + k]);
      bus_if.SAD16x8[k*15 +: 15] = 15'(csad[c][88 + k]);
    end
    for (int k = 0; k < 4; k++) bus_if.SAD16x16[k*16 +: 16] = 16'(csad[c][96 + k]);
    for (int k = 0; k < 2; k++) begin
      bus_if.SAD16x32[k*17 +: 17] = 17'(csad[c][100 + k]);
      bus_if.SAD32x16[k*17 +: 17] = 17'(csad[c][102 + k]);
    end
    bus_if.SAD32x32 = 18'(csad[c][104]);
    bus_if.cand_mv  = 14'(mvpack(cmx[c], cmy[c]));
  endtask

  task automatic run_search(input string name, input bit gaps, input bit poke_start);
    compute_expected();
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    chk({name, "_ready"}, 32'(bus_if.sad_ready), 1);
    chk({name, "_busy"}, 32'(bus_if.busy), 1);
    for (int c = 0; c < NC; c++) begin
      drive_cand(c);
      bus_if.sad_valid = 1'b1;
      tick();
      chk($sformatf("%s_done_c%0d", name, c), 32'(bus_if.done), (c == NC - 1) ? 1 : 0);
      if (c == 0) chk({name, "_hold_prev"}, 32'(bus_if.best_sad[17:0]), prev_sad0);
      if (gaps && c < NC - 1) begin
        bus_if.sad_valid = 1'b0;
        drive_zero();
        bus_if.start = poke_start;
        tick();
        bus_if.start = 1'b0;
        chk($sformatf("%s_gap_done_c%0d", name, c), 32'(bus_if.done), 0);
        chk($sformatf("%s_gap_ready_c%0d", name, c), 32'(bus_if.sad_ready), 1);
      end
    end
    bus_if.sad_valid = 1'b0;
    chk({name, "_done_busy"}, 32'(bus_if.busy), 1);
    chk({name, "_done_ready"}, 32'(bus_if.sad_ready), 0);
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("%s_sad[%0d]", name, p), 32'(bus_if.best_sad[p*18 +: 18]), esad[p]);
      chk($sformatf("%s_mv[%0d]", name, p), 32'(bus_if.best_mv[p*14 +: 14]), mvpack(emx[p], emy[p]));
    end
    tick();
    chk({name, "_done_low"}, 32'(bus_if.done), 0);
    chk({name, "_idle_busy"}, 32'(bus_if.busy), 0);
    prev_sad0 = esad[0];
    $display("search %s: candidates=%0d best_sad[0]=%0d best_sad[104]=%0d", name, NC, esad[0], esad[104]);
  endtask

  initial begin
    rst_n = 1'b0;
    bus_if.start = 1'b0;
    bus_if.sad_valid = 1'b0;
    drive_zero();
    repeat (3) tick();
    chk("rst_ready", 32'(bus_if.sad_ready), 0);
    chk("rst_busy", 32'(bus_if.busy), 0);
    chk("rst_done", 32'(bus_if.done), 0);
    chk("rst_best_sad", 32'(|bus_if.best_sad), 0);
    chk("rst_best_mv", 32'(|bus_if.best_mv), 0);
    rst_n = 1'b1;
    tick();

    // sad_valid in IDLE must not be accepted (zero SADs would otherwise win).
    bus_if.sad_valid = 1'b1;
    repeat (3) begin
      tick();
      chk("idle_ready", 32'(bus_if.sad_ready), 0);
      chk("idle_busy", 32'(bus_if.busy), 0);
    end
    bus_if.sad_valid = 1'b0;
    $display("idle: sad_valid held 3 cycles outside SEARCH");

    // Basic: 100,50,50,70 with mvs (0,0),(1,2),(3,-1),(0,0).
    for (int p = 0; p < NP; p++) begin
      csad[0][p] = 100; csad[1][p] = 50; csad[2][p] = 50; csad[3][p] = 70;
    end
    cmx[0] = 0; cmy[0] = 0; cmx[1] = 1; cmy[1] = 2;
    cmx[2] = 3; cmy[2] = -1; cmx[3] = 0; cmy[3] = 0;
    run_search("basic", 1'b0, 1'b0);
    chk("basic_const_sad0", 32'(bus_if.best_sad[17:0]), 50);
    chk("basic_const_mv104", 32'(bus_if.best_mv[104*14 +: 14]), 32'h101);

    // Ties: identical SAD on every candidate.
    for (int p = 0; p < NP; p++) begin
      int v;
      v = rnd_sad(p);
      for (int c = 0; c < NC; c++) csad[c][p] = v;
    end
    for (int c = 0; c < NC; c++) begin
      cmx[c] = 0;
      cmy[c] = 0;
    end
    cmx[0] = -5; cmy[0] = 9;
    for (int c = 1; c < NC; c++) begin
      cmx[c] = int'($urandom_range(0, 127)) - 64;
      cmy[c] = int'($urandom_range(0, 127)) - 64;
    end
    run_search("ties", 1'b0, 1'b0);
    chk("ties_mv_first", 32'(bus_if.best_mv[50*14 +: 14]), mvpack(-5, 9));

    // Distinct minima per partition: p5 wins at candidate 2, p104 at candidate 3.
    for (int c = 0; c < NC; c++) begin
      for (int p = 0; p < NP; p++) csad[c][p] = int'($urandom_range(600, 4000));
      cmx[c] = int'($urandom_range(0, 15)) - 8;
      cmy[c] = int'($urandom_range(0, 15)) - 8;
    end
    cmx[2] = 7; cmy[2] = -3; cmx[3] = -6; cmy[3] = 4;
    csad[2][5] = 0;
    csad[3][104] = 0;
    run_search("distinct", 1'b0, 1'b0);
    chk("distinct_mv5", 32'(bus_if.best_mv[5*14 +: 14]), mvpack(7, -3));
    chk("distinct_mv104", 32'(bus_if.best_mv[104*14 +: 14]), mvpack(-6, 4));

    // Random data, sad_valid gaps, start poked mid-search.
    for (int c = 0; c < NC; c++) begin
      for (int p = 0; p < NP; p++) csad[c][p] = rnd_sad(p);
      cmx[c] = int'($urandom_range(0, 127)) - 64;
      cmy[c] = int'($urandom_range(0, 127)) - 64;
    end
    run_search("gaps", 1'b1, 1'b1);

    // Reset after two accepts aborts the search with no done pulse.
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    drive_zero();
    bus_if.sad_valid = 1'b1;
    repeat (2) tick();
    bus_if.sad_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus_if.busy), 0);
    chk("abort_ready", 32'(bus_if.sad_ready), 0);
    chk("abort_best_sad", 32'(|bus_if.best_sad), 0);
    chk("abort_best_mv", 32'(|bus_if.best_mv), 0);
    repeat (4) begin
      tick();
      chk("abort_done", 32'(bus_if.done), 0);
    end
    rst_n = 1'b1;
    prev_sad0 = 0;
    tick();
    chk("abort_done_after", 32'(bus_if.done), 0);
    $display("abort: reset after 2 accepts");

    for (int c = 0; c < NC; c++) begin
      for (int p = 0; p < NP; p++) csad[c][p] = rnd_sad(p);
      cmx[c] = int'($urandom_range(0, 127)) - 64;
      cmy[c] = int'($urandom_range(0, 127)) - 64;
    end
    run_search("restart", 1'b1, 1'b0);

`ifdef SAD_MVCOST_EN
    for (int p = 0; p < NP; p++) begin
      csad[0][p] = 40; csad[1][p] = 45; csad[2][p] = 200; csad[3][p] = 200;
    end
    cmx[0] = 8; cmy[0] = 0;
    for (int c = 1; c < NC; c++) begin
      cmx[c] = 0;
      cmy[c] = 0;
    end
    run_search("mvcost", 1'b0, 1'b0);
    chk("mvcost_sad104", 32'(bus_if.best_sad[104*18 +: 18]), 45);
    chk("mvcost_mv104", 32'(bus_if.best_mv[104*14 +: 14]), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
